// File: rtl/arm_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_step_ctrl_if
// Description : Board-side control bundle for arm_step_ctrl. It carries the
//               raw key/switch inputs, the core halt request, and the enable,
//               retire count and mode outputs.
//               master : board / test driver (drives key, switch, halt)
//               slave  : arm_step_ctrl (drives cpu_en, step_count, mode)
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_step_ctrl_if;
    logic        key_step_n;   // raw pushbutton, active-low, asynchronous
    logic        run_sw;       // raw run switch, 1 = free-run, asynchronous
    logic        halt_req;     // core halt request, clk-synchronous level
    logic        cpu_en;       // registered clock-enable to the core
    logic [15:0] step_count;   // number of cpu_en cycles issued
    logic [1:0]  mode;         // 00 IDLE, 01 PULSE, 10 RUN

    modport master (
        output key_step_n, run_sw, halt_req,
        input  cpu_en, step_count, mode
    );

    modport slave (
        input  key_step_n, run_sw, halt_req,
        output cpu_en, step_count, mode
    );
endinterface
`default_nettype wire

// File: rtl/arm_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arm_step_ctrl
// Description : Clock-enable controller for the ARM core. It synchronizes and
//               debounces the step key, synchronizes the run switch, and
//               issues cpu_en in one of three modes: halted, single-step (one
//               enable per debounced press) or free-run (one enable every
//               RUN_DIV cycles). It also counts every enable it issues.
// Ports       : clk   - CLOCK_50, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - arm_step_ctrl_if.slave (key/switch/halt in,
//                       cpu_en/step_count/mode out)
// Revision    : 1.0 - initial release
// ============================================================================
module arm_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 50
) (
    input  logic           clk,
    input  logic           rst_n,
    arm_step_ctrl_if.slave bus
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(RUN_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_PULSE = 2'b01;
    localparam logic [1:0] c_RUN   = 2'b10;

    logic               r_key_meta;
    logic               r_key_s;
    logic               r_run_meta;
    logic               r_run_s;
    logic               r_stable;
    logic               r_stable_d;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [1:0]         r_state;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_cpu_en;
    logic [15:0]        r_step_count;

    logic               w_press;
    logic [1:0]         w_state_next;
    logic               w_stay_run;
    logic               w_div_tc;
    logic               w_cpu_en_next;

    // Two-flop synchronizers. The key idles high (released), the switch low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
        end else begin
            r_key_meta <= bus.key_step_n;
            r_key_s    <= r_key_meta;
            r_run_meta <= bus.run_sw;
            r_run_s    <= r_run_meta;
        end
    end

    // Debouncer: a new key level is accepted only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles. Because
    // stable resets to 1, a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_stable_d <= r_stable;
            if (r_key_s == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_MAX) begin
                r_stable <= r_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Single-cycle strobe on the accepted 1->0 edge only; releases are ignored.
    assign w_press = r_stable_d & ~r_stable;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                // Run takes priority over a coincident press. Steps from IDLE
                // stay legal during halt_req so the core can be stepped past
                // a halt.
                if (r_run_s && !bus.halt_req) begin
                    w_state_next = c_RUN;
                end else if (w_press && !r_run_s) begin
                    w_state_next = c_PULSE;
                end
            end
            c_PULSE: w_state_next = c_IDLE;
            c_RUN: begin
                if (!r_run_s || bus.halt_req) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    assign w_stay_run = (r_state == c_RUN) && (w_state_next == c_RUN);
    assign w_div_tc   = (r_div_cnt == c_DIV_MAX);

    // A terminal count on the edge that leaves RUN (switch off or halt)
    // issues no enable.
    assign w_cpu_en_next = ((r_state == c_IDLE) && (w_state_next == c_PULSE)) ||
                           (w_stay_run && w_div_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_div_cnt    <= '0;
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cpu_en <= w_cpu_en_next;

            // The divider only runs while staying in RUN, so it restarts
            // from 0 on every RUN entry and holds 0 elsewhere.
            if (w_stay_run) begin
                r_div_cnt <= w_div_tc ? '0 : r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end

            if (r_cpu_en) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

    assign bus.cpu_en     = r_cpu_en;
    assign bus.step_count = r_step_count;
    assign bus.mode       = r_state;

endmodule
`default_nettype wire
